// File: rtl/reg_spill_fill_if.sv
// reg_spill_fill_if: control, register-file and data-memory signals of the spill/fill engine
// slave  : engine side (takes start/mode/base_addr/reg_mask, rf_rd_data, mem_rd_data/mem_ack)
// master : core/environment side (drives the engine inputs, observes busy/done and the rf/mem requests)
interface reg_spill_fill_if #(
  parameter int pw = 2,
  parameter int aw = 8
);
  logic                   start;
  logic                   mode;
  logic [aw-1:0]          base_addr;
  logic [2**(pw+1)-1:0]   reg_mask;
  logic                   busy;
  logic                   done;
  logic [pw:0]            rf_rd_addr;
  logic [7:0]             rf_rd_data;
  logic                   rf_wr_en;
  logic [pw:0]            rf_wr_addr;
  logic [7:0]             rf_wr_data;
  logic                   mem_req;
  logic                   mem_we;
  logic [aw-1:0]          mem_addr;
  logic [7:0]             mem_wr_data;
  logic [7:0]             mem_rd_data;
  logic                   mem_ack;
  modport master (
    output start, mode, base_addr, reg_mask, rf_rd_data, mem_rd_data, mem_ack,
    input  busy, done, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data, mem_req, mem_we, mem_addr, mem_wr_data
  );
  modport slave (
    input  start, mode, base_addr, reg_mask, rf_rd_data, mem_rd_data, mem_ack,
    output busy, done, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data, mem_req, mem_we, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/reg_spill_fill.sv
// reg_spill_fill: saves masked registers to consecutive memory words or restores them back
// clk, rst_n : rising-edge clock, asynchronous active-low reset
// b          : reg_spill_fill_if.slave (start/mode/base/mask in, busy/done out, rf read/write port, memory request port)
module reg_spill_fill #(
  parameter int pw = 2,
  parameter int aw = 8
) (
  input logic             clk,
  input logic             rst_n,
  reg_spill_fill_if.slave b
);
  typedef enum logic [1:0] {IDLE, SCAN, ACCESS, DONE} state_t;
  state_t               state_q, state_d;
  logic [pw:0]          idx_q, idx_d;
  logic [aw-1:0]        cnt_q, cnt_d, base_q, base_d;
  logic [2**(pw+1)-1:0] mask_q, mask_d;
  logic                 mode_q, mode_d;
  logic                 acc, ack;
  assign acc = state_q == ACCESS;
  assign ack = acc && b.mem_ack;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: if (b.start) begin
        state_d = SCAN;
        mode_d  = b.mode;
        base_d  = b.base_addr;
        mask_d  = b.reg_mask;
        idx_d   = '0;
        cnt_d   = '0;
      end
      SCAN: begin
        state_d = mask_q[idx_q] ? ACCESS : (&idx_q ? DONE : SCAN);
        idx_d   = (mask_q[idx_q] || &idx_q) ? idx_q : idx_q + (pw+1)'(1);
      end
      ACCESS: if (b.mem_ack) begin
        state_d = &idx_q ? DONE : SCAN;
        idx_d   = idx_q + (pw+1)'(1);
        cnt_d   = cnt_q + aw'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  assign b.busy        = state_q == SCAN || acc;
  assign b.done        = state_q == DONE;
  assign b.rf_rd_addr  = idx_q;
  assign b.mem_req     = acc;
  assign b.mem_we      = acc && !mode_q;
  assign b.mem_addr    = acc ? base_q + cnt_q : '0;
  assign b.mem_wr_data = acc ? b.rf_rd_data : '0;
  assign b.rf_wr_en    = ack && mode_q;
  assign b.rf_wr_addr  = b.rf_wr_en ? idx_q : '0;
  assign b.rf_wr_data  = b.rf_wr_en ? b.mem_rd_data : '0;
endmodule
